data_mem_arbiter: RTL

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/dmem_arb_pkg.sv | 24 ++
 rtl/rr_arbiter2.sv | 30 +++
 rtl/data_mem_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
// Contents: FSM state encoding, requester index constants (CPU/DMA), the
// default memory size in bytes, and the word-address legality check.
package dmem_arb_pkg;

  localparam int unsigned MEM_BYTES = 128;

  // Requester indices into the packed per-requester buses
  localparam int unsigned CPU = 0;
  localparam int unsigned DMA = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // A legal access is word aligned and the whole word fits inside memory
  function automatic logic addr_legal(input logic [31:0] addr,
                                      input int unsigned mem_bytes);
    return (addr[1:0] == 2'b00) && (addr <= 32'(mem_bytes - 4));
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin tie-break.
// Ports:
//   req    - request bits, [CPU] and [DMA]
//   last   - index of the previous winner
//   gnt    - one-hot grant (all zero when nothing is requested)
//   winner - index of the granted requester
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       winner
);

  // On a tie the requester that did not win last time goes first
  always_comb begin
    winner = 1'b0;
    gnt    = 2'b00;
    if (req[CPU] && req[DMA]) begin
      winner = ~last;
    end else begin
      winner = req[DMA];
    end
    if (|req) begin
      gnt[winner] = 1'b1;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates CPU and DMA accesses onto a single data-memory port.
// Every access runs IDLE -> ACCESS -> RESP; the winner's request is latched
// at grant, the memory strobe fires in ACCESS, done/err pulse in RESP.
// Ports:
//   clk_i, rst_i         - clock, synchronous active-high reset
//   req_i, we_i          - per-requester request and write enable
//   addr_i, wdata_i      - packed per-requester byte address / write data
//   done_o, err_o        - per-requester completion pulse and error flag
//   rdata_o              - read data, held until the next read completes
//   busy_o               - FSM not idle
//   mem_addr_o/mem_data_o/mem_read_o/mem_write_o/mem_data_i - memory port
module data_mem_arbiter #(
  parameter int unsigned MEM_BYTES = dmem_arb_pkg::MEM_BYTES,
  parameter int unsigned NREQ      = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ-1:0]   we_i,
  input  logic [NREQ*32-1:0] addr_i,
  input  logic [NREQ*32-1:0] wdata_i,
  output logic [NREQ-1:0]   done_o,
  output logic [NREQ-1:0]   err_o,
  output logic [31:0]       rdata_o,
  output logic              busy_o,
  output logic [31:0]       mem_addr_o,
  output logic [31:0]       mem_data_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [31:0]       mem_data_i
);

  import dmem_arb_pkg::*;

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        win_q, win_d;
  logic        we_q, we_d;
  logic        legal_q, legal_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic [1:0]  arb_gnt;
  logic        arb_winner;
  logic        grant;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

  rr_arbiter2 u_arb (
    .req    (req_i),
    .last   (last_q),
    .gnt    (arb_gnt),
    .winner (arb_winner)
  );

  // Arbitration result only matters while idle
  assign grant     = (state_q == ST_IDLE) && (|arb_gnt);
  assign sel_addr  = arb_winner ? addr_i[DMA*32 +: 32]  : addr_i[CPU*32 +: 32];
  assign sel_wdata = arb_winner ? wdata_i[DMA*32 +: 32] : wdata_i[CPU*32 +: 32];

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (|req_i) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Request latch at grant and read-data capture at the end of ACCESS
  always_comb begin
    last_d  = last_q;
    win_d   = win_q;
    we_d    = we_q;
    legal_d = legal_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (grant) begin
      last_d  = arb_winner;
      win_d   = arb_winner;
      we_d    = we_i[arb_winner];
      addr_d  = sel_addr;
      wdata_d = sel_wdata;
      legal_d = addr_legal(sel_addr, MEM_BYTES);
    end
    if ((state_q == ST_ACCESS) && !we_q) begin
      rdata_d = legal_q ? mem_data_i : 32'h0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      legal_q <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      last_q  <= last_d;
      win_q   <= win_d;
      we_q    <= we_d;
      legal_q <= legal_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Output decode; the write strobe is masked by reset so a write whose
  // commit edge coincides with reset never reaches memory
  always_comb begin
    done_o      = '0;
    err_o       = '0;
    busy_o      = (state_q != ST_IDLE);
    mem_read_o  = (state_q == ST_ACCESS) && legal_q && !we_q;
    mem_write_o = (state_q == ST_ACCESS) && legal_q && we_q && !rst_i;
    if (state_q == ST_RESP) begin
      done_o[win_q] = 1'b1;
      err_o[win_q]  = ~legal_q;
    end
  end

  assign rdata_o    = rdata_q;
  assign mem_addr_o = addr_q;
  assign mem_data_o = wdata_q;

endmodule
